branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Pipelined, parametrised branch resolution stage; successor to the combinational branch comparator.
- Takes operands, RISC-V branch funct3, a predicted-taken bit and a tag, then produces registered taken / mispredict results.
- Uses valid/ready handshakes on both sides and supports flush.
- Sits between the EX operand muxes and the fetch redirect logic.

Parameters:
- XLEN, 32, operand width in bits (>=2).
- STAGES, 1, pipeline depth; legal values 1 or 2.
- TAG_W, 5, width of the tag carried alongside each branch (ROB/PC index).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush_i  input  1  kill all in-flight entries.
- valid_i  input  1  input beat valid.
- ready_o  output  1  unit can accept an input beat.
- rs1_i  input  XLEN  operand A.
- rs2_i  input  XLEN  operand B.
- funct3_i  input  3  branch type.
- pred_taken_i  input  1  front-end prediction.
- tag_i  input  TAG_W  opaque tag.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts the result.
- taken_o  output  1  branch resolved taken.
- eq_o  output  1  rs1 == rs2.
- lt_o  output  1  less-than, signed or unsigned as selected by funct3.
- mispredict_o  output  1  taken_o != pred_taken.
- illegal_o  output  1  funct3 is not a branch encoding.
- tag_o  output  TAG_W  tag of the result.
- br_count_o  output  32  resolved-branch count (optional feature).
- mispred_count_o  output  32  mispredict count (optional feature).

Behaviour:
- Reset: rst asserted forces every output to 0 at once, except ready_o, which is 1. All stage valid bits clear. Counters clear.
- funct3 decode:
  - 000 BEQ: taken = eq.
  - 001 BNE: taken = !eq.
  - 100 BLT: signed less-than.
  - 101 BGE: !(signed less-than).
  - 110 BLTU: unsigned less-than.
  - 111 BGEU: !(unsigned less-than).
  - 010 / 011: illegal_o = 1, taken_o = 0, mispredict_o = pred_taken.
- lt_o uses signed compare when funct3[1] = 0 and unsigned compare when funct3[1] = 1. Full XLEN width, no truncation.
- Equal operands give eq = 1 and lt = 0 in both signednesses.
- Input handshake fires when valid_i & ready_o. Output handshake fires when valid_o & ready_i.
- Latency:
  - STAGES = 1: compare, decode and register in one stage; result appears the cycle after the input handshake.
  - STAGES = 2: stage 1 registers eq / lts / ltu plus funct3, pred and tag; stage 2 registers taken / mispredict / illegal. Latency is 2 cycles.
- Flow control:
  - Each stage loads when it is empty or the next stage is advancing.
  - ready_o = !v[0] | advance[0].
  - With ready_i held at 1 and no flush, throughput is 1 beat per cycle.
  - When ready_i = 0, the last stage holds all outputs stable. Earlier stages fill, then ready_o drops.
- Flush:
  - Synchronous; clears all stage valid bits at the next edge.
  - Has priority over a same-cycle input handshake: that beat is dropped.
  - Takes effect even while ready_i = 0.
  - Counters do not count flushed entries.
- Output payload is don't-care when valid_o = 0, but must not contain X after reset.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- Defined:
  - br_count_o increments on each output handshake.
  - mispred_count_o increments on each output handshake with mispredict_o = 1.
  - Illegal entries count in br_count_o only.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package branch_pkg holds:
  - the funct3 localparams (F3_BEQ … F3_BGEU);
  - the brcmp_t struct {eq, lts, ltu};
  - the brres_t struct {taken, mispredict, illegal, tag}.
- Sub-module branch_cmp_core (combinational, XLEN-parametrised) produces eq / lts / ltu. It is instantiated once at the stage-1 input.

Test Plan:
- STAGES = 1, XLEN = 32: rs1 = 32'hFFFF_FFFF, rs2 = 1. BLT -> taken 1, lt 1. BLTU -> taken 0. Each result appears 1 cycle after the handshake.
- rs1 = rs2 = 32'h8000_0000 for each of the 6 funct3 -> eq 1, lt 0; taken = 1 only for BEQ, BGE and BGEU.
- funct3 = 3'b010 with pred_taken 1 -> illegal_o 1, taken 0, mispredict 1.
- STAGES = 2:
  - Stream 4 back-to-back beats with tags 0..3 -> valid_o on cycles 2..5, tags in order.
  - Hold ready_i = 0 for 3 cycles -> outputs stable, ready_o falls after 2 accepted beats, and no beat is lost or duplicated.
- Flush while 2 entries are in flight and valid_i = 1 in the same cycle -> next cycle valid_o = 0, all 3 entries are discarded, ready_o = 1.
- With BRANCH_RESOLVE_STATS_EN:
  - 10 resolved branches, 3 of them mispredicted -> br_count 10, mispred_count 3.
  - rst mid-stream -> both counts 0 and valid_o 0 immediately.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch-resolution types, funct3 encodings and decode helpers.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Widest tag any instance may carry; narrower tags are zero-extended into it.
    localparam int TAG_W_MAX = 16;

    typedef struct packed {
        logic eq;
        logic lts;
        logic ltu;
    } brcmp_t;

    typedef struct packed {
        logic                 taken;
        logic                 mispredict;
        logic                 illegal;
        logic [TAG_W_MAX-1:0] tag;
    } brres_t;

    function automatic brres_t resolve_branch(input brcmp_t cmp, input logic [2:0] funct3,
                                              input logic pred, input logic [TAG_W_MAX-1:0] tag);
        brres_t res;
        res.tag     = tag;
        res.illegal = 1'b0;
        case (funct3)
            F3_BEQ:  res.taken = cmp.eq;
            F3_BNE:  res.taken = !cmp.eq;
            F3_BLT:  res.taken = cmp.lts;
            F3_BGE:  res.taken = !cmp.lts;
            F3_BLTU: res.taken = cmp.ltu;
            F3_BGEU: res.taken = !cmp.ltu;
            default: begin
                res.taken   = 1'b0;
                res.illegal = 1'b1;
            end
        endcase
        res.mispredict = res.taken ^ pred;
        return res;
    endfunction

    function automatic logic lt_select(input brcmp_t cmp, input logic [2:0] funct3);
        return funct3[1] ? cmp.ltu : cmp.lts;
    endfunction

endpackage

// File: rtl/branch_cmp_core.sv
// Full-width equality plus signed and unsigned less-than of two operands.
module branch_cmp_core
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output brcmp_t          cmp_res
);

    // All three relations are evaluated in parallel; the caller picks by funct3.
    always_comb begin
        cmp_res.eq  = (rs1 == rs2);
        cmp_res.lts = ($signed(rs1) < $signed(rs2));
        cmp_res.ltu = (rs1 < rs2);
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch resolution (STAGES = 1 or 2) with valid/ready flow control and flush.
// Resolved/mispredict statistics counters exist only when BRANCH_RESOLVE_STATS_EN is defined.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic              pred_taken_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              taken_o,
    output logic              eq_o,
    output logic              lt_o,
    output logic              mispredict_o,
    output logic              illegal_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [31:0]       br_count_o,
    output logic [31:0]       mispred_count_o
);

    brcmp_t               cmp_s;
    logic [TAG_W_MAX-1:0] tag_ext_s;
    logic                 load_out_s;
    logic                 nxt_valid_s;
    brres_t               nxt_res_s;
    logic                 nxt_eq_s;
    logic                 nxt_lt_s;
    logic                 out_valid_r;
    brres_t               res_r;
    logic                 eq_r;
    logic                 lt_r;
    logic                 tag_unused_s;

    branch_cmp_core #(.XLEN(XLEN)) u_cmp (
        .rs1     (rs1_i),
        .rs2     (rs2_i),
        .cmp_res (cmp_s)
    );

    // Zero-extend the tag into the shared tag field (TAG_W must not exceed TAG_W_MAX).
    always_comb begin
        tag_ext_s            = '0;
        tag_ext_s[TAG_W-1:0] = tag_i;
    end

    assign load_out_s = !out_valid_r | ready_i;

    generate
        if (STAGES == 1) begin : g_single
            // Decode straight from the comparator into the output stage.
            always_comb begin
                nxt_valid_s = valid_i;
                nxt_res_s   = resolve_branch(cmp_s, funct3_i, pred_taken_i, tag_ext_s);
                nxt_eq_s    = cmp_s.eq;
                nxt_lt_s    = lt_select(cmp_s, funct3_i);
                ready_o     = load_out_s;
            end
        end else begin : g_double
            logic                 s1_valid_r;
            brcmp_t               s1_cmp_r;
            logic [2:0]           s1_f3_r;
            logic                 s1_pred_r;
            logic [TAG_W_MAX-1:0] s1_tag_r;
            logic                 s1_load_s;

            assign s1_load_s = !s1_valid_r | load_out_s;

            // Stage 1 keeps raw compare flags so the decode lands in stage 2.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid_r <= 1'b0;
                    s1_cmp_r   <= '0;
                    s1_f3_r    <= 3'b000;
                    s1_pred_r  <= 1'b0;
                    s1_tag_r   <= '0;
                end else if (flush_i) begin
                    s1_valid_r <= 1'b0;
                end else if (s1_load_s) begin
                    s1_valid_r <= valid_i;
                    if (valid_i) begin
                        s1_cmp_r  <= cmp_s;
                        s1_f3_r   <= funct3_i;
                        s1_pred_r <= pred_taken_i;
                        s1_tag_r  <= tag_ext_s;
                    end
                end
            end

            // Present the stage-1 entry to the output stage.
            always_comb begin
                nxt_valid_s = s1_valid_r;
                nxt_res_s   = resolve_branch(s1_cmp_r, s1_f3_r, s1_pred_r, s1_tag_r);
                nxt_eq_s    = s1_cmp_r.eq;
                nxt_lt_s    = lt_select(s1_cmp_r, s1_f3_r);
                ready_o     = s1_load_s;
            end
        end
    endgenerate

    // Output stage holds its payload while the consumer stalls; flush only drops valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            res_r       <= '0;
            eq_r        <= 1'b0;
            lt_r        <= 1'b0;
        end else if (flush_i) begin
            out_valid_r <= 1'b0;
        end else if (load_out_s) begin
            out_valid_r <= nxt_valid_s;
            if (nxt_valid_s) begin
                res_r <= nxt_res_s;
                eq_r  <= nxt_eq_s;
                lt_r  <= nxt_lt_s;
            end
        end
    end

    assign valid_o      = out_valid_r;
    assign taken_o      = res_r.taken;
    assign mispredict_o = res_r.mispredict;
    assign illegal_o    = res_r.illegal;
    assign eq_o         = eq_r;
    assign lt_o         = lt_r;
    assign tag_o        = res_r.tag[TAG_W-1:0];
    assign tag_unused_s = ^res_r.tag;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] br_count_r;
    logic [31:0] mispred_count_r;
    logic        count_fire_s;

    assign count_fire_s = out_valid_r & ready_i & !flush_i;

    // Saturating counts of delivered results and of delivered mispredicts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_r      <= 32'd0;
            mispred_count_r <= 32'd0;
        end else if (count_fire_s) begin
            if (br_count_r != 32'hFFFF_FFFF) begin
                br_count_r <= br_count_r + 32'd1;
            end
            if (res_r.mispredict && (mispred_count_r != 32'hFFFF_FFFF)) begin
                mispred_count_r <= mispred_count_r + 32'd1;
            end
        end
    end

    assign br_count_o      = br_count_r;
    assign mispred_count_o = mispred_count_r;
`else
    assign br_count_o      = 32'd0;
    assign mispred_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: one instance per pipeline depth, a queue-style
// reference model checked every cycle, plus hand-computed literal expectations.
module tb_branch_resolve_unit;

    typedef struct {
        int         acc;
        logic       tk;
        logic       eq;
        logic       lt;
        logic       mp;
        logic       il;
        logic [4:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  fl, vi, ro, rdy, vo, tk, eqo, lto, mpo, ilo, pr;
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [2:0]  f3 [2];
    logic [4:0]  tg [2];
    logic [4:0]  tago [2];
    logic [31:0] bco [2];
    logic [31:0] mco [2];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    exp_t        q [2][16];
    int          hd [2];
    int          cnt [2];
    int          lastpop [2];
    logic [31:0] bc [2];
    logic [31:0] mc [2];

    branch_resolve_unit #(.XLEN(32), .STAGES(1), .TAG_W(5)) u_dut1 (
        .clk(clk), .rst(rst), .flush_i(fl[0]), .valid_i(vi[0]), .ready_o(ro[0]),
        .rs1_i(a[0]), .rs2_i(b[0]), .funct3_i(f3[0]), .pred_taken_i(pr[0]), .tag_i(tg[0]),
        .valid_o(vo[0]), .ready_i(rdy[0]), .taken_o(tk[0]), .eq_o(eqo[0]), .lt_o(lto[0]),
        .mispredict_o(mpo[0]), .illegal_o(ilo[0]), .tag_o(tago[0]),
        .br_count_o(bco[0]), .mispred_count_o(mco[0]));

    branch_resolve_unit #(.XLEN(32), .STAGES(2), .TAG_W(5)) u_dut2 (
        .clk(clk), .rst(rst), .flush_i(fl[1]), .valid_i(vi[1]), .ready_o(ro[1]),
        .rs1_i(a[1]), .rs2_i(b[1]), .funct3_i(f3[1]), .pred_taken_i(pr[1]), .tag_i(tg[1]),
        .valid_o(vo[1]), .ready_i(rdy[1]), .taken_o(tk[1]), .eq_o(eqo[1]), .lt_o(lto[1]),
        .mispredict_o(mpo[1]), .illegal_o(ilo[1]), .tag_o(tago[1]),
        .br_count_o(bco[1]), .mispred_count_o(mco[1]));

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int st(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic exp_t predict(input logic [31:0] x, input logic [31:0] y, input logic [2:0] f,
                                     input logic p, input logic [4:0] t, input int acc);
        exp_t e;
        logic lts, ltu;
        e.acc = acc;
        e.tag = t;
        e.eq  = (x == y);
        lts   = ($signed(x) < $signed(y));
        ltu   = (x < y);
        e.il  = 1'b0;
        case (f)
            3'd0: e.tk = e.eq;
            3'd1: e.tk = !e.eq;
            3'd4: e.tk = lts;
            3'd5: e.tk = !lts;
            3'd6: e.tk = ltu;
            3'd7: e.tk = !ltu;
            default: begin e.tk = 1'b0; e.il = 1'b1; end
        endcase
        e.lt = f[1] ? ltu : lts;
        e.mp = (e.tk != p);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] f, input logic p, input logic [4:0] t);
        vi[d] = v; a[d] = x; b[d] = y; f3[d] = f; pr[d] = p; tg[d] = t;
    endtask

    // Reference model: tracks accepted beats per instance and checks every output each cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                cnt[d] = 0; hd[d] = 0; lastpop[d] = -1; bc[d] = 32'd0; mc[d] = 32'd0;
            end else begin
                exp_t h;
                int   vis;
                bit   ev, rexp, fo, fi;
                h   = q[d][hd[d]];
                vis = h.acc + st(d);
                if (lastpop[d] + 1 > vis) vis = lastpop[d] + 1;
                ev   = (cnt[d] > 0) && (vis <= cyc);
                rexp = (cnt[d] < st(d)) || rdy[d];
                chk($sformatf("valid_o%0d", d), vo[d], ev);
                chk($sformatf("ready_o%0d", d), ro[d], rexp);
                if (ev) begin
                    chk($sformatf("taken%0d", d), tk[d], h.tk);
                    chk($sformatf("eq%0d", d), eqo[d], h.eq);
                    chk($sformatf("lt%0d", d), lto[d], h.lt);
                    chk($sformatf("mispredict%0d", d), mpo[d], h.mp);
                    chk($sformatf("illegal%0d", d), ilo[d], h.il);
                    chk($sformatf("tag%0d", d), tago[d], h.tag);
                end
`ifdef BRANCH_RESOLVE_STATS_EN
                chk($sformatf("br_count%0d", d), bco[d], bc[d]);
                chk($sformatf("mispred_count%0d", d), mco[d], mc[d]);
`else
                chk($sformatf("br_count%0d", d), bco[d], 32'd0);
                chk($sformatf("mispred_count%0d", d), mco[d], 32'd0);
`endif
                fo = ev && rdy[d];
                fi = vi[d] && rexp;
                if (fl[d]) begin
                    cnt[d] = 0;
                end else begin
                    if (fo) begin
                        bc[d] = bc[d] + 32'd1;
                        if (h.mp) mc[d] = mc[d] + 32'd1;
                        hd[d] = (hd[d] + 1) % 16;
                        cnt[d] = cnt[d] - 1;
                        lastpop[d] = cyc;
                    end
                    if (fi) begin
                        q[d][(hd[d] + cnt[d]) % 16] = predict(a[d], b[d], f3[d], pr[d], tg[d], cyc);
                        cnt[d] = cnt[d] + 1;
                    end
                end
            end
        end
    end

    // Directed stimulus with literal expectations.
    initial begin
        logic [2:0] f6 [6];
        f6 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        rst = 1'b1; fl = 2'b00; vi = 2'b00; rdy = 2'b11; pr = 2'b00;
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 5'd0);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ready%0d", d), ro[d], 32'd1);
            chk($sformatf("rst_valid%0d", d), vo[d], 32'd0);
            chk($sformatf("rst_payload%0d", d), {tk[d], eqo[d], lto[d], mpo[d], ilo[d], tago[d]}, 32'd0);
            chk($sformatf("rst_counts%0d", d), bco[d] | mco[d], 32'd0);
        end
        step(); step();
        rst = 1'b0;
        step();

        // Signed vs unsigned compare of -1 and 1, STAGES = 1.
        drive(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b100, 1'b0, 5'd1);
        step();
        chk("blt_valid", vo[0], 32'd1);
        chk("blt_taken", tk[0], 32'd1);
        chk("blt_lt", lto[0], 32'd1);
        chk("blt_mispredict", mpo[0], 32'd1);
        drive(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b110, 1'b0, 5'd2);
        step();
        chk("bltu_taken", tk[0], 32'd0);
        chk("bltu_lt", lto[0], 32'd0);
        chk("bltu_tag", tago[0], 32'd2);

        // Equal operands across all six branch types.
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 32'h8000_0000, 32'h8000_0000, f6[i], 1'b0, 5'(i + 3));
            step();
            chk($sformatf("eqops_taken_f%0d", f6[i]), tk[0], (i == 0 || i == 3 || i == 5) ? 32'd1 : 32'd0);
            chk($sformatf("eqops_eq_f%0d", f6[i]), eqo[0], 32'd1);
            chk($sformatf("eqops_lt_f%0d", f6[i]), lto[0], 32'd0);
        end

        // Illegal funct3 with a taken prediction.
        drive(0, 1'b1, 32'd5, 32'd9, 3'b010, 1'b1, 5'd9);
        step();
        chk("illegal_flag", ilo[0], 32'd1);
        chk("illegal_taken", tk[0], 32'd0);
        chk("illegal_mispredict", mpo[0], 32'd1);
        vi[0] = 1'b0;
        step();

        // STAGES = 2: four back-to-back beats.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 32'(i), 32'd2, 3'b000, 1'b0, 5'(i));
            step();
            chk($sformatf("stream_valid_%0d", i), vo[1], (i >= 1) ? 32'd1 : 32'd0);
            if (i >= 1) chk($sformatf("stream_tag_%0d", i), tago[1], 32'(i - 1));
        end
        vi[1] = 1'b0;
        step();
        chk("stream_tag_last", tago[1], 32'd3);
        step();
        chk("stream_drained", vo[1], 32'd0);

        // Output stall for three cycles.
        rdy[1] = 1'b0;
        drive(1, 1'b1, 32'd4, 32'd1, 3'b101, 1'b1, 5'd4);
        step();
        chk("stall_ready_1", ro[1], 32'd1);
        drive(1, 1'b1, 32'd1, 32'd4, 3'b101, 1'b1, 5'd5);
        step();
        chk("stall_ready_2", ro[1], 32'd0);
        chk("stall_tag_a", tago[1], 32'd4);
        drive(1, 1'b1, 32'd7, 32'd7, 3'b001, 1'b0, 5'd6);
        step();
        chk("stall_ready_3", ro[1], 32'd0);
        chk("stall_tag_b", tago[1], 32'd4);
        chk("stall_taken_b", tk[1], 32'd1);
        rdy[1] = 1'b1;
        step();
        vi[1] = 1'b0;
        chk("unstall_tag5", tago[1], 32'd5);
        step();
        chk("unstall_tag6", tago[1], 32'd6);
        step();

        // Flush with two entries in flight and a beat offered.
        drive(1, 1'b1, 32'd1, 32'd1, 3'b000, 1'b0, 5'd8);
        step();
        drive(1, 1'b1, 32'd2, 32'd1, 3'b000, 1'b0, 5'd9);
        rdy[1] = 1'b0;
        step();
        chk("preflush_tag", tago[1], 32'd8);
        drive(1, 1'b1, 32'd3, 32'd1, 3'b000, 1'b0, 5'd10);
        fl[1] = 1'b1;
        step();
        fl[1] = 1'b0; vi[1] = 1'b0;
        chk("flush_valid", vo[1], 32'd0);
        chk("flush_ready", ro[1], 32'd1);
        rdy[1] = 1'b1;
        step();
        chk("flush_empty", vo[1], 32'd0);

        // Flush beats a same-cycle accepted input.
        drive(1, 1'b1, 32'd1, 32'd1, 3'b000, 1'b0, 5'd11);
        step();
        drive(1, 1'b1, 32'd1, 32'd1, 3'b000, 1'b0, 5'd12);
        fl[1] = 1'b1;
        step();
        fl[1] = 1'b0; vi[1] = 1'b0;
        step();
        chk("flush_drop_a", vo[1], 32'd0);
        step();
        chk("flush_drop_b", vo[1], 32'd0);

        // Statistics: ten branches, three mispredicted, one illegal.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) drive(0, 1'b1, 32'd3, 32'd3, 3'b011, 1'b0, 5'(i));
            else        drive(0, 1'b1, 32'd3, 32'd3, 3'b000, (i >= 3) ? 1'b1 : 1'b0, 5'(i));
            step();
        end
        vi[0] = 1'b0;
        step(); step();
`ifdef BRANCH_RESOLVE_STATS_EN
        chk("stats_br", bco[0], 32'd10);
        chk("stats_mis", mco[0], 32'd3);
`else
        chk("stats_br", bco[0], 32'd0);
        chk("stats_mis", mco[0], 32'd0);
`endif

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 32'd1, 32'd2, 3'b100, 1'b0, 5'(i));
            drive(1, 1'b1, 32'd1, 32'd2, 3'b100, 1'b0, 5'(i));
            step();
        end
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("midrst_valid%0d", d), vo[d], 32'd0);
            chk($sformatf("midrst_ready%0d", d), ro[d], 32'd1);
            chk($sformatf("midrst_counts%0d", d), bco[d] | mco[d], 32'd0);
        end
        vi = 2'b00;
        step();
        rst = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
